// File: rtl/debounce_pkg.sv
// Shared types for the debounce_signal block.
package debounce_pkg;

  // Qualification FSM states: idle/matched vs. candidate change being timed.
  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_signal_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last flop.
module sync_chain #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // Plain shift chain; no logic between flops so metastability has a full cycle to settle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chain_q <= {STAGES{RESET_LEVEL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_signal.sv
// Debouncer: synchronizes a bouncing input, requires DEBOUNCE_CYCLES consecutive
// differing samples before flipping sig_out, strobes toggled on each flip and
// counts aborted qualifications (saturating).
module debounce_signal
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        RESET_LEVEL     = 1'b1,
  parameter int unsigned BOUNCE_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sig_in,
  input  logic                bounce_clr,
  output logic                sig_out,
  output logic                toggled,
  output logic                busy,
  output logic [BOUNCE_W-1:0] bounce_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("debounce_signal: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("debounce_signal: SYNC_STAGES must be >= 2");
  end

  logic                sync;
  db_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sig_q, sig_d;
  logic                tog_q, tog_d;
  logic                busy_q;
  logic [BOUNCE_W-1:0] bounce_q, bounce_d;
  logic                abort;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sig_in),
    .q     (sync)
  );

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= DB_STABLE;
      cnt_q    <= '0;
      sig_q    <= RESET_LEVEL;
      tog_q    <= 1'b0;
      busy_q   <= 1'b0;
      bounce_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      tog_q    <= tog_d;
      busy_q   <= (state_d == DB_CHECK);
      bounce_q <= bounce_d;
    end
  end

  // Next-state: qualify a candidate change, flip on the last qualifying cycle, abort on return.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    tog_d   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      DB_STABLE: begin
        if (sync != sig_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            sig_d = sync;
            tog_d = 1'b1;
          end else begin
            state_d = DB_CHECK;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      DB_CHECK: begin
        if (sync == sig_q) begin
          abort   = 1'b1;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          sig_d   = sync;
          tog_d   = 1'b1;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bounce counter: clear has priority over an abort on the same edge; saturates at all-ones.
  always_comb begin
    bounce_d = bounce_q;
    if (bounce_clr) begin
      bounce_d = '0;
    end else if (abort && (bounce_q != '1)) begin
      bounce_d = bounce_q + BOUNCE_W'(1);
    end
  end

  assign sig_out      = sig_q;
  assign toggled      = tog_q;
  assign busy         = busy_q;
  assign bounce_count = bounce_q;

endmodule

// File: tb/tb_debounce_signal.sv
// Randomized + directed bench for debounce_signal against a run-length reference model.
module tb_debounce_signal;

  localparam int unsigned D  = 4;
  localparam int unsigned SS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sig_in = 1'b0;
  logic       bounce_clr = 1'b0;
  logic       sig_out, toggled, busy;
  logic [7:0] bounce_count;
  logic       sig_out2, toggled2, busy2;
  logic [1:0] bounce_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int tog_cnt  = 0;

  // Reference model: input delay line, run length of differing samples, counts.
  bit m_hist [SS];
  bit m_out, m_tog;
  int m_run, m_bc8, m_bc2;

  always #5 clk = ~clk;

  debounce_signal #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (SS),
    .RESET_LEVEL     (1'b1),
    .BOUNCE_W        (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .bounce_clr   (bounce_clr),
    .sig_out      (sig_out),
    .toggled      (toggled),
    .busy         (busy),
    .bounce_count (bounce_count)
  );

  debounce_signal #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (SS),
    .RESET_LEVEL     (1'b1),
    .BOUNCE_W        (2)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .bounce_clr   (bounce_clr),
    .sig_out      (sig_out2),
    .toggled      (toggled2),
    .busy         (busy2),
    .bounce_count (bounce_count2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of one clock edge: the FSM sees the input sampled SS edges earlier;
  // sig_out flips once D consecutive seen samples differ from it.
  task automatic model_edge();
    bit seen, abort_now;
    if (!reset) begin
      for (int i = 0; i < SS; i++) m_hist[i] = 1'b1;
      m_out = 1'b1; m_tog = 1'b0; m_run = 0; m_bc8 = 0; m_bc2 = 0;
    end else begin
      seen = m_hist[SS-1];
      for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = sig_in;
      m_tog = 1'b0;
      abort_now = 1'b0;
      if (seen != m_out) begin
        m_run++;
        if (m_run == D) begin
          m_out = seen; m_tog = 1'b1; m_run = 0;
        end
      end else begin
        abort_now = (m_run > 0);
        m_run = 0;
      end
      if (bounce_clr) begin
        m_bc8 = 0; m_bc2 = 0;
      end else if (abort_now) begin
        if (m_bc8 < 255) m_bc8++;
        if (m_bc2 < 3)   m_bc2++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("sig_out",  sig_out,       m_out);
    check_eq("toggled",  toggled,       m_tog);
    check_eq("busy",     busy,          m_run > 0);
    check_eq("bounce8",  bounce_count,  m_bc8);
    check_eq("sig_out2", sig_out2,      m_out);
    check_eq("bounce2",  bounce_count2, m_bc2);
    if (toggled) tog_cnt++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state with sig_in low.
    sig_in = 1'b0;
    do_reset(3);
    check_eq("rst_sig_out", sig_out, 1);
    check_eq("rst_bounce", bounce_count, 0);

    // Held 1->0: busy after edges 3..5, flip exactly on edge 6.
    sig_in = 1'b0;
    tog_cnt = 0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e >= 3 && e <= 5) check_eq("lat_busy", busy, 1);
      if (e == 5) check_eq("lat_early", sig_out, 1);
      if (e == 6) begin
        check_eq("lat_sig", sig_out, 0);
        check_eq("lat_tog", toggled, 1);
      end
      if (e == 7) check_eq("lat_tog_off", toggled, 0);
    end
    check_eq("lat_tog_cnt", tog_cnt, 1);

    // Short low pulse of 3 cycles: rejected, one abort.
    do_reset(1);
    tog_cnt = 0;
    sig_in = 1'b0;
    repeat (3) step();
    sig_in = 1'b1;
    repeat (6) step();
    check_eq("short_sig", sig_out, 1);
    check_eq("short_tog_cnt", tog_cnt, 0);
    check_eq("short_bounce", bounce_count, 1);
    check_eq("short_busy", busy, 0);

    // Five glitches of 1..3 cycles then steady low.
    do_reset(1);
    tog_cnt = 0;
    for (int g = 0; g < 5; g++) begin
      sig_in = 1'b0;
      repeat ((g % 3) + 1) step();
      sig_in = 1'b1;
      repeat (3) step();
    end
    sig_in = 1'b0;
    repeat (10) step();
    check_eq("glitch_bounce", bounce_count, 5);
    check_eq("glitch_tog_cnt", tog_cnt, 1);

    // Reset in the middle of a qualification (counter at 2).
    do_reset(1);
    sig_in = 1'b0;
    repeat (4) step();
    check_eq("mid_busy_pre", busy, 1);
    reset = 1'b0;
    step();
    check_eq("mid_sig", sig_out, 1);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_tog", toggled, 0);
    check_eq("mid_bounce", bounce_count, 0);
    reset = 1'b1;

    // Saturation on the 2-bit counter, then clear on an abort edge.
    sig_in = 1'b1;
    repeat (3) step();
    for (int g = 0; g < 5; g++) begin
      sig_in = 1'b0;
      step();
      sig_in = 1'b1;
      repeat (3) step();
    end
    check_eq("sat_bounce2", bounce_count2, 3);
    check_eq("sat_bounce8", bounce_count, 5);
    sig_in = 1'b0;
    step();
    sig_in = 1'b1;
    step();
    step();
    bounce_clr = 1'b1;
    step();
    bounce_clr = 1'b0;
    check_eq("clr_win2", bounce_count2, 0);
    check_eq("clr_win8", bounce_count, 0);

    // Random runs of varying length with occasional clear and reset.
    for (int r = 0; r < 600; r++) begin
      int unsigned len;
      logic        val;
      val = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int unsigned k = 0; k < len; k++) begin
        sig_in     = val;
        bounce_clr = ($urandom_range(0, 49) == 0);
        reset      = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    reset = 1'b1;
    bounce_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
